// File: rtl/qspi_rom_reader.sv
// Quad I/O read initiator: sends command, address and dummy clocks, then streams
// bytes from the external ROM one data_valid pulse per byte.
module qspi_rom_reader #(
   parameter int         ADDR_BITS    = 24,
   parameter int         LEN_BITS     = 8,
   parameter int         DUMMY_CYCLES = 6,
   parameter logic [7:0] CMD_BYTE     = 8'hEB
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [LEN_BITS-1:0]  req_len,
   output logic [7:0]           data_out,
   output logic                 data_valid,
   output logic                 done,
   output logic                 busy,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic [3:0]           spi_io_out,
   output logic [3:0]           spi_io_oe,
   input  logic [3:0]           spi_io_in
);

   localparam int NIBS  = ADDR_BITS / 4;
   localparam int CNT_W = $clog2(ADDR_BITS + DUMMY_CYCLES + 9);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END} state_t;

   state_t               state;
   state_t               next_state;
   logic                 sclk;
   logic [CNT_W-1:0]     cnt;
   logic [ADDR_BITS-1:0] addr_q;
   logic [LEN_BITS-1:0]  remaining;
   logic [3:0]           hi_nib;
   logic                 active;
   logic                 fall;
   logic [2:0]           cmd_idx;

   function automatic logic [3:0] addr_nibble(input logic [ADDR_BITS-1:0] a,
                                              input logic [CNT_W-1:0] idx);
      logic [ADDR_BITS-1:0] s;
      s = a >> (4 * (NIBS - 1 - int'(idx)));
      return s[3:0];
   endfunction

   assign active  = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
   // The coming clk edge takes spi_clk 1->0; phase counters and IO only move then.
   assign fall    = active & sclk;
   assign cmd_idx = 3'd7 - cnt[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (req_valid) next_state = (req_len == '0) ? END : CMD;
         CMD:   if (fall && cnt == CNT_W'(7)) next_state = ADDR;
         ADDR:  if (fall && cnt == CNT_W'(NIBS - 1))
                   next_state = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
         DUMMY: if (fall && cnt == CNT_W'(DUMMY_CYCLES - 1)) next_state = DATA;
         DATA:  if (fall && cnt[0] && remaining == LEN_BITS'(1)) next_state = END;
         END:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk       <= 1'b0;
         cnt        <= '0;
         addr_q     <= '0;
         remaining  <= '0;
         hi_nib     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         sclk       <= active ? ~sclk : 1'b0;
         data_valid <= 1'b0;
         if (state == IDLE && req_valid) begin
            addr_q    <= req_addr;
            remaining <= req_len;
         end
         if (next_state != state) cnt <= '0;
         else if (fall)           cnt <= cnt + CNT_W'(1);
         // DATA: even cnt is the high nibble, odd cnt the low nibble of a byte
         if (state == DATA) begin
            if (!sclk) begin
               if (!cnt[0]) begin
                  hi_nib <= spi_io_in;
               end else begin
                  data_out   <= {hi_nib, spi_io_in};
                  data_valid <= 1'b1;
               end
            end else if (cnt[0]) begin
               remaining <= remaining - LEN_BITS'(1);
            end
         end
      end
   end

   always_comb begin
      req_ready  = (state == IDLE);
      busy       = active;
      done       = (state == END);
      spi_cs_n   = ~active;
      spi_clk    = sclk;
      spi_io_oe  = 4'b0000;
      spi_io_out = 4'b0000;
      case (state)
         CMD: begin
            spi_io_oe  = 4'b0001;
            spi_io_out = {3'b000, CMD_BYTE[cmd_idx]};
         end
         ADDR: begin
            spi_io_oe  = 4'b1111;
            spi_io_out = addr_nibble(addr_q, cnt);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_qspi_rom_reader.sv
// Bench for qspi_rom_reader: ROM emulator on the SPI side, cycle-timed model of the
// request side checked every cycle, plus hand-computed expectations per scenario.
module tb_qspi_rom_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic [7:0]  req_len;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        done;
   logic        busy;
   logic        spi_cs_n;
   logic        spi_clk;
   logic [3:0]  spi_io_out;
   logic [3:0]  spi_io_oe;
   logic [3:0]  spi_io_in = 4'h0;

   always #5 clk = ~clk;

   qspi_rom_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .data_out   (data_out),
      .data_valid (data_valid),
      .done       (done),
      .busy       (busy),
      .spi_cs_n   (spi_cs_n),
      .spi_clk    (spi_clk),
      .spi_io_out (spi_io_out),
      .spi_io_oe  (spi_io_oe),
      .spi_io_in  (spi_io_in)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rom(input logic [23:0] a);
      if (a == 24'h000FFC) return 8'h00;
      if (a == 24'h000FFD) return 8'hF0;
      return (a[7:0] ^ 8'hA5) + a[15:8];
   endfunction

   // ROM emulator: counts SPI rises in a frame, captures command/address, serves data
   int          f_rise = 0;
   logic [23:0] f_addr = '0;
   logic [7:0]  f_io0  = '0;
   logic [3:0]  f_nib [6];
   bit          f_oe_bad = 1'b0;

   always @(posedge spi_clk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         f_rise = 0;
      end else begin
         if (f_rise < 8) begin
            f_io0[7 - f_rise] = spi_io_out[0];
         end else if (f_rise < 14) begin
            f_nib[f_rise - 8] = spi_io_out;
            f_addr = {f_addr[19:0], spi_io_out};
         end else if (spi_io_oe != 4'h0) begin
            f_oe_bad = 1'b1;
         end
         f_rise++;
      end
   end

   always @(negedge spi_clk or posedge spi_cs_n) begin
      int idx;
      logic [7:0] b;
      if (spi_cs_n !== 1'b0 || f_rise < 20) begin
         spi_io_in = 4'h0;
      end else begin
         idx = f_rise - 20;
         b = rom(f_addr + 24'(idx / 2));
         spi_io_in = (idx % 2 == 0) ? b[7:4] : b[3:0];
      end
   end

   // Reference model: a transaction accepted in cycle A with length L>0 owns the
   // bus for cycles A+1..A+40+4L, byte i lands at A+44+4i, done at A+41+4L.
   bit          m_active = 1'b0;
   int          m_a;
   int          m_len;
   logic [23:0] m_addr;
   int          n_acc = 0;
   int          acc_cyc[$];
   int          dv_cyc[$];
   logic [7:0]  dv_byte[$];
   int          done_cyc[$];

   always @(negedge clk) begin
      int          d;
      int          last;
      logic        e_ready, e_cs, e_clk, e_done, e_dv;
      logic [3:0]  e_oe, e_out;
      logic [7:0]  e_data;
      logic [7:0]  cmd_v;
      logic [23:0] sh;
      cyc++;
      if (!rst_n) begin
         m_active = 1'b0;
         chk("rst_cs_n", spi_cs_n, 1);
         chk("rst_spi_clk", spi_clk, 0);
         chk("rst_oe", spi_io_oe, 0);
         chk("rst_io_out", spi_io_out, 0);
         chk("rst_req_ready", req_ready, 1);
         chk("rst_data_valid", data_valid, 0);
         chk("rst_done", done, 0);
         chk("rst_busy", busy, 0);
         chk("rst_data_out", data_out, 0);
      end else begin
         cmd_v = 8'hEB;
         e_ready = 1; e_cs = 1; e_clk = 0; e_done = 0; e_dv = 0;
         e_oe = 0; e_out = 0; e_data = 0;
         if (m_active) begin
            d = cyc - m_a;
            if (m_len == 0) begin
               last = 1;
               if (d == 1) begin
                  e_done  = 1;
                  e_ready = 0;
               end
            end else begin
               last = 41 + 4 * m_len;
               if (d <= last) e_ready = 0;
               if (d == last) e_done = 1;
               if (d < last) begin
                  e_cs  = 0;
                  e_clk = (d % 2 == 0);
                  if (d <= 16) begin
                     e_oe  = 4'b0001;
                     e_out = {3'b000, cmd_v[7 - (d - 1) / 2]};
                  end else if (d <= 28) begin
                     e_oe  = 4'b1111;
                     sh    = m_addr >> (4 * (5 - (d - 17) / 2));
                     e_out = sh[3:0];
                  end
                  if (d >= 44 && (d - 44) % 4 == 0) begin
                     e_dv   = 1;
                     e_data = rom(m_addr + 24'((d - 44) / 4));
                  end
               end
            end
            if (d > last) m_active = 1'b0;
         end
         chk("req_ready", req_ready, e_ready);
         chk("spi_cs_n", spi_cs_n, e_cs);
         chk("busy", busy, !e_cs);
         chk("spi_clk", spi_clk, e_clk);
         chk("done", done, e_done);
         chk("data_valid", data_valid, e_dv);
         chk("spi_io_oe", spi_io_oe, e_oe);
         chk("spi_io_out", spi_io_out, e_out);
         if (e_dv) chk("data_out", data_out, e_data);
         if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(data_out);
         end
         if (done) done_cyc.push_back(cyc);
         if (e_ready && req_valid) begin
            m_active = 1'b1;
            m_a      = cyc;
            m_len    = req_len;
            m_addr   = req_addr;
            n_acc++;
            acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic clear_logs();
      dv_cyc.delete();
      dv_byte.delete();
      done_cyc.delete();
   endtask

   // Holds req_valid until the model sees acceptance; returns the accept cycle.
   task automatic wait_accept(output int a);
      int prev;
      prev = n_acc;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (n_acc > prev) break;
      end
      chk("accepted", n_acc > prev, 1);
      a = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size() - 1] : 0;
   endtask

   task automatic start_req(input logic [23:0] addr, input logic [7:0] len, output int a);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      wait_accept(a);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         if (!m_active) break;
      end
      chk("idle_reached", m_active, 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         a;
      int         a2;
      logic [7:0] cmd_exp;
      logic [3:0] nib_exp [6];
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Two-byte read at the top of a page, with bus-level checks
      clear_logs();
      start_req(24'h000FFC, 8'd2, a);
      wait_idle();
      chk("ffc_dv_count", dv_cyc.size(), 2);
      if (dv_cyc.size() == 2) begin
         chk("ffc_dv0_time", dv_cyc[0] - a, 44);
         chk("ffc_dv0_byte", dv_byte[0], 8'h00);
         chk("ffc_dv1_time", dv_cyc[1] - a, 48);
         chk("ffc_dv1_byte", dv_byte[1], 8'hF0);
      end
      chk("ffc_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1) chk("ffc_done_time", done_cyc[0] - a, 49);
      cmd_exp = 8'hEB;
      for (int i = 0; i < 8; i++) chk("cmd_io0_bit", f_io0[7 - i], cmd_exp[7 - i]);
      nib_exp = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hC};
      for (int i = 0; i < 6; i++) chk("addr_nibble", f_nib[i], nib_exp[i]);
      chk("oe_low_dummy_data", f_oe_bad, 0);

      // Zero-length request
      clear_logs();
      start_req(24'h000123, 8'd0, a);
      wait_idle();
      chk("zero_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1) chk("zero_done_time", done_cyc[0] - a, 1);
      chk("zero_no_data", dv_cyc.size(), 0);

      // Back-to-back one-byte requests with req_valid held high
      clear_logs();
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_addr  = 24'h000100;
      req_len   = 8'd1;
      wait_accept(a);
      #1 req_addr = 24'h000200;
      wait_accept(a2);
      #1 req_valid = 1'b0;
      wait_idle();
      chk("b2b_accept_gap", a2 - a, 46);
      chk("b2b_dv_count", dv_cyc.size(), 2);
      if (dv_cyc.size() == 2) begin
         chk("b2b_byte0", dv_byte[0], 8'hA6);
         chk("b2b_byte1", dv_byte[1], 8'hA7);
      end

      // Stray request while DATA is streaming must be ignored
      clear_logs();
      start_req(24'h003010, 8'd3, a);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (cyc >= a + 46) break;
      end
      #1;
      req_valid = 1'b1;
      req_addr  = 24'hABCDEF;
      req_len   = 8'd7;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle();
      chk("stray_dv_count", dv_cyc.size(), 3);
      if (dv_cyc.size() == 3) begin
         chk("stray_byte0", dv_byte[0], 8'hE5);
         chk("stray_byte1", dv_byte[1], 8'hE4);
         chk("stray_byte2", dv_byte[2], 8'hE7);
      end
      if (done_cyc.size() == 1) chk("stray_done_time", done_cyc[0] - a, 53);
      else chk("stray_done_count", done_cyc.size(), 1);

      // Maximum length read
      clear_logs();
      start_req(24'h000080, 8'd255, a);
      wait_idle();
      chk("max_dv_count", dv_cyc.size(), 255);
      if (done_cyc.size() == 1) chk("max_done_time", done_cyc[0] - a, 1061);
      else chk("max_done_count", done_cyc.size(), 1);

      // Reset on the second byte of a four-byte read
      clear_logs();
      start_req(24'h000400, 8'd4, a);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (cyc >= a + 47) break;
      end
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_cs_n", spi_cs_n, 1);
      chk("midrst_spi_clk", spi_clk, 0);
      chk("midrst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("midrst_ready", req_ready, 1);
      chk("midrst_no_done", done_cyc.size(), 0);
      chk("midrst_dv_count", dv_cyc.size(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qspi_rom_reader.md
Name: qspi_rom_reader

Overview:
- QSPI read initiator that fetches bytes from the external program ROM on behalf of the core/cartridge bus.
- Accepts a request with a start address and byte count, then runs one chip-select-framed Quad I/O read transaction.
- Sequence: 8-bit command, quad address, dummy clocks, then streams bytes back one-per-pulse.
- Sits between the address/fetch logic and the top-level uio pins; the bench pairs it with the ROM emulator.

Parameters:
- ADDR_BITS, 24, flash address width; must be a multiple of 4; sent as ADDR_BITS/4 nibbles.
- LEN_BITS, 8, width of the byte-count field.
- DUMMY_CYCLES, 6, SPI clocks between the last address nibble and the first data nibble.
- CMD_BYTE, 8'hEB, command byte, shifted out serially.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when idle; a request is accepted on a cycle where req_valid and req_ready are both high.
- req_addr  in  ADDR_BITS  start byte address.
- req_len  in  LEN_BITS  number of bytes to read.
- data_out  out  8  fetched byte.
- data_valid  out  1  one-cycle pulse; data_out is valid in that cycle.
- done  out  1  one-cycle pulse after the last byte, or after a zero-length request.
- busy  out  1  a transaction is in progress.
- spi_cs_n  out  1  chip select, active low.
- spi_clk  out  1  SPI clock, clk/2, idle low.
- spi_io_out  out  4  IO drive value.
- spi_io_oe  out  4  per-bit output enable.
- spi_io_in  in  4  IO sample.

Behaviour:
- Reset (async, rst_n=0): all outputs reset immediately.
  - spi_cs_n=1, spi_clk=0, spi_io_oe=0, spi_io_out=0.
  - req_ready=1, data_valid=0, done=0, busy=0, data_out=0.
  - FSM returns to IDLE; any transaction in flight is abandoned with no done pulse.
- States: IDLE, CMD, ADDR, DUMMY, DATA, END.
- Accept cycle A. The address and length are latched in cycle A, and req_ready=0 from A+1.
- Zero-length request: no SPI activity; done=1 in cycle A+1; req_ready=1 in A+2.
- Otherwise:
  - spi_cs_n=0 and busy=1 from cycle A+1.
  - spi_clk toggles every clk, starting low in A+1. Rising edge k (k=0,1,…) appears in cycle A+2+2k.
  - All IO changes happen only in cycles where spi_clk=0 (i.e. on the falling edge).
  - spi_io_in is sampled at the clk edge where spi_clk goes 0→1.
- CMD (rises 0–7):
  - spi_io_oe=4'b0001, IO0 carries CMD_BYTE MSB first, IO[3:1]=0.
- ADDR (next ADDR_BITS/4 rises):
  - spi_io_oe=4'b1111, spi_io_out carries address nibbles, most significant nibble first.
- DUMMY (next DUMMY_CYCLES rises):
  - spi_io_oe=0.
- DATA:
  - spi_io_oe=0. Each byte takes two rises: high nibble first, then low nibble.
  - data_out and data_valid update in the same cycle as the low-nibble rise.
  - Address auto-increment belongs to the flash; this block does not resend the address.
  - With defaults, the first data_valid is in cycle A+44; subsequent bytes follow every 4 cycles.
- END:
  - spi_clk returns low in the cycle after the last rise, and spi_cs_n=1 in the same cycle.
  - done=1 and busy=0 in that cycle.
  - spi_cs_n stays high for at least 2 cycles; req_ready=1 from the 2nd cycle.
- req_valid is ignored while req_ready=0; the latched request is not disturbed.
- The byte counter is LEN_BITS wide. req_len = max (255) performs 255 bytes with no wrap-around.
- The address field is not incremented internally, so address wrap is the flash's concern.
- data_valid and done never coincide.
- No backpressure: the consumer must take each byte in its data_valid cycle.

Test Plan:
- Reset mid-DATA: assert rst_n=0 on the 2nd byte of a 4-byte read → same cycle: spi_cs_n=1, spi_clk=0, busy=0; no done; req_ready=1 after release.
- req_addr=24'h000FFC, req_len=2, ROM[FFC]=8'h00, ROM[FFD]=8'hF0:
  - data_valid at A+44 with 8'h00, and at A+48 with 8'hF0.
  - done at A+49; spi_cs_n high at A+49.
- Bus check during the same read:
  - IO0 over the 8 rises = 1,1,1,0,1,0,1,1.
  - Address nibbles = 0,0,0,F,F,C.
  - spi_io_oe=0 for all DUMMY and DATA rises.
- req_len=0 → no spi_cs_n activity; done pulse at A+1; req_ready=1 at A+2.
- Back-to-back: req_valid held high with two 1-byte requests → second accepted only after spi_cs_n has been high ≥2 cycles; second data byte is correct.
- req_valid pulsed during DATA with a different address → ignored; the byte stream and done timing are unchanged.
